// File: rtl/servo_pwm_rx_sched.sv
// Buffers per-channel capture results, round-robins them onto one valid/ready stream, flags overrun/loss.
// Optional out-of-range flagging when SERVO_PWM_RX_RANGE_CHECK_EN is defined.
module servo_pwm_rx_sched #(
  parameter int NUM_CH = 4,
  parameter int TICK_W = 12,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TICK_W-1:0]        cfg_ui_clk_ticks,
  input  logic [NUM_CH-1:0]        cfg_ch_en,
  input  logic [TICK_W-1:0]        cfg_timeout_ui,
  input  logic [TICK_W-1:0]        cfg_min_ui,
  input  logic [TICK_W-1:0]        cfg_max_ui,
  input  logic                     cfg_clr_status,
  output logic [TICK_W-1:0]        ui_clk_ticks,
  input  logic [NUM_CH*TICK_W-1:0] rx_ticks,
  input  logic [NUM_CH-1:0]        rx_dv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [TICK_W-1:0]        out_ui_ticks,
  output logic                     out_range_err,
  output logic [NUM_CH-1:0]        sts_overrun,
  output logic [NUM_CH-1:0]        sts_lost
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_t;

  state_t             state_r;
  logic [TICK_W-1:0]  hold_r [NUM_CH];
  logic [NUM_CH-1:0]  pending_r;
  logic [CH_W-1:0]    rr_r;
  logic [NUM_CH-1:0]  accept_s;
  logic [NUM_CH-1:0]  load_s;
  logic [CH_W-1:0]    grant_s;
  logic [CH_W-1:0]    idx_s;
  logic               found_s;
  logic               range_err_s;
  logic [TICK_W-1:0]  pre_r;
  logic               strobe_s;
  logic [TICK_W-1:0]  los_cnt_r [NUM_CH];
  logic [TICK_W-1:0]  los_cnt_nxt_s [NUM_CH];

  assign accept_s = rx_dv & cfg_ch_en;

  // Round-robin search: first pending channel after the last grant, wrapping.
  always_comb begin
    grant_s = {CH_W{1'b0}};
    found_s = 1'b0;
    idx_s   = {CH_W{1'b0}};
    for (int k = 1; k <= NUM_CH; k++) begin
      idx_s = CH_W'((int'(rr_r) + k) % NUM_CH);
      if (!found_s && pending_r[idx_s]) begin
        grant_s = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot of the channel being moved into the output register this cycle.
  always_comb begin
    load_s = {NUM_CH{1'b0}};
    if (state_r == ST_IDLE && found_s) begin
      load_s[grant_s] = 1'b1;
    end else begin
      load_s = {NUM_CH{1'b0}};
    end
  end

`ifdef SERVO_PWM_RX_RANGE_CHECK_EN
  // Inclusive window check on the value being granted.
  always_comb begin
    range_err_s = (hold_r[grant_s] < cfg_min_ui) || (hold_r[grant_s] > cfg_max_ui);
  end
`else
  logic unused_range_cfg;
  assign unused_range_cfg = ^{cfg_min_ui, cfg_max_ui};
  assign range_err_s      = 1'b0;
`endif

  // Capture buffers, pending flags, sticky overrun and config fan-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      ui_clk_ticks <= {TICK_W{1'b0}};
      pending_r    <= {NUM_CH{1'b0}};
      sts_overrun  <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) hold_r[i] <= {TICK_W{1'b0}};
    end else begin
      ui_clk_ticks <= cfg_ui_clk_ticks;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!cfg_ch_en[i]) begin
          pending_r[i] <= 1'b0;
        end else if (rx_dv[i]) begin
          hold_r[i]    <= rx_ticks[i*TICK_W +: TICK_W];
          pending_r[i] <= 1'b1;
        end else if (load_s[i]) begin
          pending_r[i] <= 1'b0;
        end else begin
          pending_r[i] <= pending_r[i];
        end
      end
      // A same-edge load hands off the old value, so that case is not an overrun.
      sts_overrun <= (sts_overrun & ~{NUM_CH{cfg_clr_status}}) | (accept_s & pending_r & ~load_s);
    end
  end

  // Output handshake FSM with registered beat fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      out_valid     <= 1'b0;
      out_ch        <= {CH_W{1'b0}};
      out_ui_ticks  <= {TICK_W{1'b0}};
      out_range_err <= 1'b0;
      rr_r          <= CH_W'(NUM_CH - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            out_ch        <= grant_s;
            out_ui_ticks  <= hold_r[grant_s];
            out_range_err <= range_err_s;
            rr_r          <= grant_s;
            out_valid     <= 1'b1;
            state_r       <= ST_PRESENT;
          end else begin
            out_valid <= 1'b0;
          end
        end
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    strobe_s = (ui_clk_ticks != {TICK_W{1'b0}}) && (pre_r >= ui_clk_ticks - TICK_W'(1));
  end

  // UI prescaler; a zero period holds it at 0 and stops all loss timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= {TICK_W{1'b0}};
    end else if (ui_clk_ticks == {TICK_W{1'b0}} || strobe_s) begin
      pre_r <= {TICK_W{1'b0}};
    end else begin
      pre_r <= pre_r + TICK_W'(1);
    end
  end

  // Saturating per-channel UI counters since the last accepted strobe.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      los_cnt_nxt_s[i] = los_cnt_r[i];
      if (accept_s[i]) begin
        los_cnt_nxt_s[i] = {TICK_W{1'b0}};
      end else if (strobe_s && (los_cnt_r[i] != {TICK_W{1'b1}})) begin
        los_cnt_nxt_s[i] = los_cnt_r[i] + TICK_W'(1);
      end else begin
        los_cnt_nxt_s[i] = los_cnt_r[i];
      end
    end
  end

  // Counters start saturated so every channel reads lost until its first strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sts_lost <= {NUM_CH{1'b1}};
      for (int i = 0; i < NUM_CH; i++) los_cnt_r[i] <= {TICK_W{1'b1}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        los_cnt_r[i] <= los_cnt_nxt_s[i];
        sts_lost[i]  <= cfg_ch_en[i] && (cfg_timeout_ui != {TICK_W{1'b0}})
                        && (los_cnt_nxt_s[i] >= cfg_timeout_ui);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_rx_sched.sv
// Directed self-checking bench for servo_pwm_rx_sched (range checks follow SERVO_PWM_RX_RANGE_CHECK_EN).
module tb_servo_pwm_rx_sched;
  localparam int NUM_CH = 4;
  localparam int TICK_W = 12;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [TICK_W-1:0]        cfg_ui_clk_ticks;
  logic [NUM_CH-1:0]        cfg_ch_en;
  logic [TICK_W-1:0]        cfg_timeout_ui;
  logic [TICK_W-1:0]        cfg_min_ui;
  logic [TICK_W-1:0]        cfg_max_ui;
  logic                     cfg_clr_status;
  logic [TICK_W-1:0]        ui_clk_ticks;
  logic [NUM_CH*TICK_W-1:0] rx_ticks;
  logic [NUM_CH-1:0]        rx_dv;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_ch;
  logic [TICK_W-1:0]        out_ui_ticks;
  logic                     out_range_err;
  logic [NUM_CH-1:0]        sts_overrun;
  logic [NUM_CH-1:0]        sts_lost;

  int errors = 0;
  int checks = 0;

  logic [TICK_W-1:0] rc_val [4];
  logic              rc_exp [4];
  logic              rc_inv_exp;

  always #5 clk = ~clk;

  servo_pwm_rx_sched #(.NUM_CH(NUM_CH), .TICK_W(TICK_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_ui_clk_ticks(cfg_ui_clk_ticks), .cfg_ch_en(cfg_ch_en), .cfg_timeout_ui(cfg_timeout_ui),
    .cfg_min_ui(cfg_min_ui), .cfg_max_ui(cfg_max_ui), .cfg_clr_status(cfg_clr_status),
    .ui_clk_ticks(ui_clk_ticks), .rx_ticks(rx_ticks), .rx_dv(rx_dv),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_ui_ticks(out_ui_ticks),
    .out_range_err(out_range_err), .sts_overrun(sts_overrun), .sts_lost(sts_lost)
  );

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_dv(input int ch, input logic [TICK_W-1:0] v);
    rx_ticks[ch*TICK_W +: TICK_W] = v;
    rx_dv = 4'b0000;
    rx_dv[ch] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_dv = 4'b0000;
    cfg_clr_status = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rc_val[0] = 12'd99;  rc_val[1] = 12'd100; rc_val[2] = 12'd200; rc_val[3] = 12'd201;
`ifdef SERVO_PWM_RX_RANGE_CHECK_EN
    rc_exp[0] = 1'b1; rc_exp[1] = 1'b0; rc_exp[2] = 1'b0; rc_exp[3] = 1'b1;
    rc_inv_exp = 1'b1;
`else
    rc_exp[0] = 1'b0; rc_exp[1] = 1'b0; rc_exp[2] = 1'b0; rc_exp[3] = 1'b0;
    rc_inv_exp = 1'b0;
`endif
    rst = 1'b1;
    cfg_ui_clk_ticks = 12'd0; cfg_ch_en = 4'hF; cfg_timeout_ui = 12'd0;
    cfg_min_ui = 12'd100; cfg_max_ui = 12'd200; cfg_clr_status = 1'b0;
    rx_ticks = 48'd0; rx_dv = 4'b0000; out_ready = 1'b1;
    step(2);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ch", out_ch, 2'd0);
    check("rst_ticks", out_ui_ticks, 12'd0);
    check("rst_rerr", out_range_err, 1'b0);
    check("rst_ovr", sts_overrun, 4'h0);
    check("rst_lost", sts_lost, 4'hF);
    check("rst_ui", ui_clk_ticks, 12'd0);

    // Single beat on ch2
    rst = 1'b0; cfg_ui_clk_ticks = 12'd10; set_dv(2, 12'd150);
    step();
    rx_dv = 4'b0000;
    check("cfg_latency", ui_clk_ticks, 12'd10);
    check("t1_cyc1_valid", out_valid, 1'b0);
    check("tmo0_lost", sts_lost, 4'h0);
    step();
    check("t1_valid", out_valid, 1'b1);
    check("t1_ch", out_ch, 2'd2);
    check("t1_ticks", out_ui_ticks, 12'd150);
    step();
    check("t1_accepted", out_valid, 1'b0);
    step(3);
    check("t1_one_beat", out_valid, 1'b0);

    // Four simultaneous captures drain in channel order, then rr wraps to ch0
    do_reset();
    rx_ticks = {12'd40, 12'd30, 12'd20, 12'd10}; rx_dv = 4'hF;
    step();
    rx_dv = 4'b0000;
    check("t2_c1_valid", out_valid, 1'b0);
    for (int b = 0; b < 4; b++) begin
      step();
      check("t2_valid", out_valid, 1'b1);
      check("t2_ch", out_ch, 32'(b));
      check("t2_ticks", out_ui_ticks, 32'((b + 1) * 10));
      step();
      check("t2_gap", out_valid, 1'b0);
    end
    rx_ticks = {12'd0, 12'd0, 12'd60, 12'd50}; rx_dv = 4'b0011;
    step();
    rx_dv = 4'b0000;
    step();
    check("t2_wrap_ch", out_ch, 2'd0);
    check("t2_wrap_ticks", out_ui_ticks, 12'd50);
    step(2);
    check("t2_wrap2_ch", out_ch, 2'd1);
    check("t2_wrap2_ticks", out_ui_ticks, 12'd60);
    step();

    // Backpressure, same-edge handoff, overrun and sticky clear
    do_reset();
    out_ready = 1'b0;
    set_dv(1, 12'd100);
    step();
    set_dv(1, 12'd77);
    step();
    check("t3_valid", out_valid, 1'b1);
    check("t3_ticks", out_ui_ticks, 12'd100);
    check("t3_same_edge_no_ovr", sts_overrun, 4'h0);
    set_dv(1, 12'd101);
    step();
    rx_dv = 4'b0000;
    check("t3_ovr", sts_overrun, 4'b0010);
    step(3);
    check("t3_hold_valid", out_valid, 1'b1);
    check("t3_hold_ticks", out_ui_ticks, 12'd100);
    out_ready = 1'b1;
    step();
    check("t3_accept", out_valid, 1'b0);
    step();
    check("t3_next_valid", out_valid, 1'b1);
    check("t3_next_ticks", out_ui_ticks, 12'd101);
    step();
    check("t3_ovr_sticky", sts_overrun, 4'b0010);
    cfg_clr_status = 1'b1;
    step();
    cfg_clr_status = 1'b0;
    check("t3_clr", sts_overrun, 4'h0);
    out_ready = 1'b0;
    set_dv(1, 12'd5);
    step();
    rx_dv = 4'b0000;
    step();
    set_dv(1, 12'd6);
    step();
    set_dv(1, 12'd7); cfg_clr_status = 1'b1;
    step();
    rx_dv = 4'b0000; cfg_clr_status = 1'b0;
    check("t3_set_wins", sts_overrun, 4'b0010);
    out_ready = 1'b1;

    // Loss of signal: 10 clk per UI, timeout 5 UI
    cfg_ui_clk_ticks = 12'd10; cfg_timeout_ui = 12'd5;
    do_reset();
    step(2);
    check("t4_init_lost", sts_lost, 4'hF);
    set_dv(3, 12'd33);
    step();
    rx_dv = 4'b0000;
    check("t4_clear", sts_lost, 4'b0111);
    step(37);
    check("t4_not_yet", sts_lost, 4'b0111);
    step(18);
    check("t4_lost", sts_lost, 4'hF);
    cfg_ch_en = 4'b0111;
    step();
    check("t4_dis_lost", sts_lost, 4'b0111);
    set_dv(3, 12'd55);
    step(3);
    rx_dv = 4'b0000;
    check("t4_dis_ignored", out_valid, 1'b0);
    cfg_ch_en = 4'hF; cfg_timeout_ui = 12'd0;
    step();
    check("t4_tmo0", sts_lost, 4'h0);
    cfg_timeout_ui = 12'd5;
    step();
    check("t4_relost", sts_lost, 4'hF);
    set_dv(3, 12'd34);
    step();
    rx_dv = 4'b0000;
    check("t4_reclear", sts_lost, 4'b0111);
    cfg_ui_clk_ticks = 12'd0; cfg_timeout_ui = 12'd0;

    // Range flag at the window edges, then an inverted window
    do_reset();
    for (int r = 0; r < 4; r++) begin
      set_dv(0, rc_val[r]);
      step();
      rx_dv = 4'b0000;
      step();
      check("t5_ticks", out_ui_ticks, 32'(rc_val[r]));
      check("t5_rerr", out_range_err, rc_exp[r]);
      step();
    end
    cfg_min_ui = 12'd201; cfg_max_ui = 12'd100;
    set_dv(0, 12'd150);
    step();
    rx_dv = 4'b0000;
    step();
    check("t5_inverted", out_range_err, rc_inv_exp);
    step();

    // Reset while a beat is stalled drops it and any pending capture
    do_reset();
    out_ready = 1'b0; cfg_ui_clk_ticks = 12'd10;
    set_dv(0, 12'd11);
    step();
    set_dv(1, 12'd22);
    step();
    rx_dv = 4'b0000;
    check("t6_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    step();
    check("t6_valid", out_valid, 1'b0);
    check("t6_lost", sts_lost, 4'hF);
    check("t6_ticks", out_ui_ticks, 12'd0);
    check("t6_ui", ui_clk_ticks, 12'd0);
    rst = 1'b0; out_ready = 1'b1;
    step(4);
    check("t6_no_pending", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
